// File: rtl/lift.sv
// lift: four-floor elevator controller (Moore FSM: IDLE / UP / DOWN).
//   Tracks the car's floor and drives up/down motor enables toward the requested floor.
//   Ports: clk, rst (sync, active-high), floor_button[1:0] (level target),
//          current_floor[1:0], motor_up, motor_down (all decoded from registers).
module lift #(
  parameter int TRAVEL_CYCLES = 4  // cycles per floor, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] floor_button,
  output logic [1:0] current_floor,
  output logic       motor_up,
  output logic       motor_down
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  // Terminal count of one floor segment.
  localparam logic [7:0] CNT_LAST = 8'(TRAVEL_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [7:0] cnt_q, cnt_d;

  // 3-bit views so floor+1 / target+1 never wrap in the comparisons.
  logic [2:0] btn_w;
  logic [2:0] floor_w;

  assign btn_w   = {1'b0, floor_button};
  assign floor_w = {1'b0, floor_q};

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Strict comparisons keep UP out of floor 3 and DOWN out of floor 0.
        if (floor_button > floor_q) begin
          state_d = S_UP;
          cnt_d   = 8'd0;
        end else if (floor_button < floor_q) begin
          state_d = S_DOWN;
          cnt_d   = 8'd0;
        end
      end
      S_UP: begin
        if (cnt_q == CNT_LAST) begin
          floor_d = floor_q + 2'd1;
          cnt_d   = 8'd0;
          // Keep moving only if the target lies beyond the floor just reached.
          if (btn_w > floor_w + 3'd1) begin
            state_d = S_UP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DOWN: begin
        if (cnt_q == CNT_LAST) begin
          floor_d = floor_q - 2'd1;
          cnt_d   = 8'd0;
          // target < floor-1, written as target+1 < floor to avoid underflow.
          if (btn_w + 3'd1 < floor_w) begin
            state_d = S_DOWN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      floor_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      cnt_q   <= cnt_d;
    end
  end

  assign current_floor = floor_q;
  assign motor_up      = (state_q == S_UP);
  assign motor_down    = (state_q == S_DOWN);

endmodule

// File: tb/tb_lift.sv
// tb_lift: drives two lift instances (TRAVEL_CYCLES = 4 and 1) with shared
//   inputs and compares them every cycle against a per-instance travel model
//   (signed direction plus cycles-left-in-segment), plus directed timing checks.
module tb_lift;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'd0;

  logic [1:0] floor4, floor1;
  logic       up4, dn4, up1, dn1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 -> TRAVEL_CYCLES=4, index 1 -> TRAVEL_CYCLES=1.
  int tc[2]     = '{4, 1};
  int m_pos[2]  = '{0, 0};
  int m_dir[2]  = '{0, 0};
  int m_left[2] = '{0, 0};

  always #5 clk = ~clk;

  lift #(.TRAVEL_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .floor_button(btn),
    .current_floor(floor4), .motor_up(up4), .motor_down(dn4)
  );

  lift #(.TRAVEL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .floor_button(btn),
    .current_floor(floor1), .motor_up(up1), .motor_down(dn1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the model: the car either waits, starts a segment,
  // or counts down the segment and arrives.
  task automatic model_step(input int k, input bit r, input int b);
    if (r) begin
      m_pos[k] = 0; m_dir[k] = 0; m_left[k] = 0;
    end else if (m_dir[k] == 0) begin
      if (b != m_pos[k]) begin
        m_dir[k]  = (b > m_pos[k]) ? 1 : -1;
        m_left[k] = tc[k];
      end
    end else begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        m_pos[k] += m_dir[k];
        if ((m_dir[k] == 1 && b > m_pos[k]) || (m_dir[k] == -1 && b < m_pos[k]))
          m_left[k] = tc[k];
        else
          m_dir[k] = 0;
      end
    end
  endtask

  // Apply inputs, take one edge, then compare both instances at the falling edge.
  task automatic cycle(input logic [1:0] b, input logic r);
    rst = r;
    btn = b;
    @(posedge clk);
    model_step(0, r, int'(b));
    model_step(1, r, int'(b));
    @(negedge clk);
    check("floor_t4", 8'(floor4), 8'(m_pos[0]));
    check("up_t4",    8'(up4),    8'(m_dir[0] == 1));
    check("down_t4",  8'(dn4),    8'(m_dir[0] == -1));
    check("floor_t1", 8'(floor1), 8'(m_pos[1]));
    check("up_t1",    8'(up1),    8'(m_dir[1] == 1));
    check("down_t1",  8'(dn1),    8'(m_dir[1] == -1));
    check("excl_t4",  8'(up4 & dn4), 8'd0);
  endtask

  // Hold a request until the T=4 car stops; return motor-on cycle counts.
  task automatic run_move(input logic [1:0] b, output int n_up, output int n_dn);
    bit done = 1'b0;
    n_up = 0;
    n_dn = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle(b, 1'b0);
      if (up4) n_up++;
      if (dn4) n_dn++;
      if (!up4 && !dn4) done = 1'b1;
    end
    check("move_timeout", 8'(done), 8'd1);
  endtask

  initial begin
    int nu, nd;
    logic [1:0] exp_mot[10];
    logic [1:0] rb;
    int hold;

    // Reset held two cycles while a request is present.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle(2'd2, 1'b1);
      check("rst_floor", 8'(floor4), 8'd0);
      check("rst_motor", 8'({up4, dn4}), 8'd0);
    end

    // 0 -> 2: eight cycles of motor_up.
    run_move(2'd2, nu, nd);
    check("up2_cycles", 8'(nu), 8'd8);
    check("up2_floor",  8'(floor4), 8'd2);

    // 2 -> 0: eight cycles of motor_down.
    run_move(2'd0, nu, nd);
    check("dn2_cycles", 8'(nd), 8'd8);
    check("dn2_floor",  8'(floor4), 8'd0);

    // 0 -> 1: one segment.
    run_move(2'd1, nu, nd);
    check("up1_cycles", 8'(nu), 8'd4);
    check("up1_floor",  8'(floor4), 8'd1);
    run_move(2'd0, nu, nd);
    check("back0_floor", 8'(floor4), 8'd0);

    // Request 3, lowered to 1 at cycle 2 of the first segment: stop at 1.
    cycle(2'd3, 1'b0);
    cycle(2'd3, 1'b0);
    run_move(2'd1, nu, nd);
    check("chg_up_cycles", 8'(nu + 2), 8'd4);
    check("chg_floor",     8'(floor4), 8'd1);
    run_move(2'd0, nu, nd);
    check("chg_back_dn", 8'(nd), 8'd4);
    check("chg_back_fl", 8'(floor4), 8'd0);

    // Reversal mid-segment: 3 requested, then 0 from cycle 2 onward.
    // Expect up x4, one idle cycle at floor 1, down x4, idle at floor 0.
    for (int i = 0; i < 4; i++) exp_mot[i] = 2'b10;
    exp_mot[4] = 2'b00;
    for (int i = 5; i < 9; i++) exp_mot[i] = 2'b01;
    exp_mot[9] = 2'b00;
    for (int i = 0; i < 10; i++) begin
      cycle((i < 2) ? 2'd3 : 2'd0, 1'b0);
      check($sformatf("rev_motor%0d", i), 8'({up4, dn4}), 8'(exp_mot[i]));
      if (i == 4) check("rev_idle_floor", 8'(floor4), 8'd1);
    end
    check("rev_end_floor", 8'(floor4), 8'd0);

    // Reset mid-travel on the 1 -> 2 segment when the count is at 2.
    run_move(2'd1, nu, nd);
    cycle(2'd2, 1'b0);
    cycle(2'd2, 1'b0);
    cycle(2'd2, 1'b0);
    check("mid_moving", 8'(up4), 8'd1);
    cycle(2'd2, 1'b1);
    check("mid_rst_floor", 8'(floor4), 8'd0);
    check("mid_rst_motor", 8'({up4, dn4}), 8'd0);
    // First request after reset release is taken on the next edge.
    cycle(2'd2, 1'b0);
    check("post_rst_up", 8'(up4), 8'd1);

    // Randomized requests with random hold times and occasional resets.
    for (int n = 0; n < 600; n++) begin
      rb   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++)
        cycle(rb, ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
